sha3_unpadder: RTL

- Receive-side inverse of the SHA-3 padder. Consumes a stream of padded 64-bit rate words, one rate block at a time, and strips the SHA-3 padding from the final block.
- Padding format stripped: domain byte 0x06 after the message, zero fill, and 0x80 ORed into the last byte of the block.
- Re-emits the message as 64-bit words with is_last/byte_num framing, matching the keccak core input convention: byte 0 = bits [63:56].
- Sits between a padded-block source (loopback/verification path, DMA of padded data) and any consumer expecting unpadded framed words.

---
 rtl/sha3_pkg.sv | 29 ++
 rtl/sha3_pad_locate.sv | 26 ++
 rtl/sha3_unpadder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared constants, state encoding and byte-mask helper for the SHA-3 unpadder.
// Byte 0 of a word occupies bits [63:56].
package sha3_pkg;

   localparam int unsigned WORD_W      = 64;
   localparam int unsigned RATE_WORDS  = 9;
   localparam logic [7:0]  DOMAIN_SHA3 = 8'h06;
   localparam logic [7:0]  PAD_END     = 8'h80;

   typedef enum logic [1:0] {
      ACCEPT,
      SCAN,
      EMIT
   } state_e;

   // Keep bytes 0..keep-1 of a word and zero bytes keep..7.
   function automatic logic [WORD_W-1:0] mask_from_byte(input logic [WORD_W-1:0] word,
                                                        input logic [2:0]        keep);
      logic [WORD_W-1:0] mask;
      mask = '0;
      for (int i = 0; i < 8; i++) begin
         if (3'(i) < keep) begin
            mask[WORD_W-1-8*i -: 8] = 8'hff;
         end
      end
      return word & mask;
   endfunction

endpackage

// File: rtl/sha3_pad_locate.sv
// Finds the highest-index nonzero byte of a word (byte 0 = bits [63:56]).
// Purely combinational; found_o=0 when the word is all zero.
module sha3_pad_locate
   import sha3_pkg::*;
(
   input  logic [WORD_W-1:0] word_i,
   output logic              found_o,
   output logic [2:0]        idx_o,
   output logic [7:0]        value_o
);

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      value_o = '0;
      // Later iterations override earlier ones, so the highest index wins.
      for (int i = 0; i < 8; i++) begin
         if (word_i[WORD_W-1-8*i -: 8] != 8'h00) begin
            found_o = 1'b1;
            idx_o   = 3'(i);
            value_o = word_i[WORD_W-1-8*i -: 8];
         end
      end
   end

endmodule

// File: rtl/sha3_unpadder.sv
// Strips SHA-3 padding (domain byte, zero fill, trailing 0x80) from the final rate block and
// re-emits the message as framed 64-bit words with out_last/out_byte_num.
module sha3_unpadder
   import sha3_pkg::*;
#(
   parameter int unsigned WORDS  = RATE_WORDS,
   parameter logic [7:0]  DOMAIN = DOMAIN_SHA3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] in,
   input  logic              in_valid,
   input  logic              in_last_block,
   output logic              in_ready,
   output logic [WORD_W-1:0] out,
   output logic              out_valid,
   output logic              out_last,
   output logic [2:0]        out_byte_num,
   input  logic              out_ready,
   output logic              err
);

   localparam int unsigned   IW       = $clog2(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] blk_q [WORDS];
   logic [WORD_W-1:0] blk_d [WORDS];
   logic [IW-1:0]     count_q, count_d;
   logic              last_blk_q, last_blk_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     end_w_q, end_w_d;
   logic [2:0]        end_b_q, end_b_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [WORD_W-1:0] out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic [2:0]        out_bn_q, out_bn_d;
   logic              err_q, err_d;

   logic              loc_found;
   logic [2:0]        loc_idx;
   logic [7:0]        loc_value;

   logic              blk_last;
   logic              load_en;
   logic [IW-1:0]     load_idx;
   logic              load_last_blk;
   logic [IW-1:0]     load_w_end;
   logic [2:0]        load_b;
   logic              is_end;

   sha3_pad_locate u_locate (
      .word_i  (blk_q[ptr_q]),
      .found_o (loc_found),
      .idx_o   (loc_idx),
      .value_o (loc_value)
   );

   always_comb begin
      state_d       = state_q;
      blk_d         = blk_q;
      count_d       = count_q;
      last_blk_d    = last_blk_q;
      ptr_d         = ptr_q;
      end_w_d       = end_w_q;
      end_b_d       = end_b_q;
      idx_d         = idx_q;
      out_d         = out_q;
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      out_bn_d      = out_bn_q;
      err_d         = 1'b0;
      blk_last      = last_blk_q;
      load_en       = 1'b0;
      load_idx      = '0;
      load_last_blk = last_blk_q;
      load_w_end    = end_w_q;
      load_b        = end_b_q;
      is_end        = 1'b0;

      unique case (state_q)
         ACCEPT: begin
            if (in_valid) begin
               blk_d[count_q] = in;
               if (count_q == '0) begin
                  last_blk_d = in_last_block;
                  blk_last   = in_last_block;
               end
               if (count_q == LAST_IDX) begin
                  count_d = '0;
                  if (!blk_last) begin
                     state_d       = EMIT;
                     load_en       = 1'b1;
                     load_last_blk = 1'b0;
                  end else if ((in[7:0] & PAD_END) == 8'h00) begin
                     // Missing final pad bit: drop the whole block.
                     err_d = 1'b1;
                  end else begin
                     blk_d[LAST_IDX] = {in[WORD_W-1:8], in[7:0] & ~PAD_END};
                     state_d         = SCAN;
                     ptr_d           = LAST_IDX;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         SCAN: begin
            if (loc_found) begin
               if (loc_value == DOMAIN) begin
                  end_w_d    = ptr_q;
                  end_b_d    = loc_idx;
                  state_d    = EMIT;
                  load_en    = 1'b1;
                  load_w_end = ptr_q;
                  load_b     = loc_idx;
               end else begin
                  err_d   = 1'b1;
                  state_d = ACCEPT;
               end
            end else if (ptr_q == '0) begin
               err_d   = 1'b1;
               state_d = ACCEPT;
            end else begin
               ptr_d = ptr_q - 1'b1;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (out_last_q || (!last_blk_q && idx_q == LAST_IDX)) begin
                  state_d     = ACCEPT;
                  out_d       = '0;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_bn_d    = '0;
               end else begin
                  load_en  = 1'b1;
                  load_idx = idx_q + 1'b1;
               end
            end
         end
         default: state_d = ACCEPT;
      endcase

      // Present word load_idx from the registered output; the end word loses its domain byte.
      if (load_en) begin
         is_end      = load_last_blk && (load_idx == load_w_end);
         idx_d       = load_idx;
         out_valid_d = 1'b1;
         out_last_d  = is_end;
         out_bn_d    = is_end ? load_b : 3'd0;
         out_d       = is_end ? mask_from_byte(blk_d[load_idx], load_b) : blk_d[load_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ACCEPT;
         count_q     <= '0;
         last_blk_q  <= 1'b0;
         ptr_q       <= '0;
         end_w_q     <= '0;
         end_b_q     <= '0;
         idx_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_bn_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         last_blk_q  <= last_blk_d;
         ptr_q       <= ptr_d;
         end_w_q     <= end_w_d;
         end_b_q     <= end_b_d;
         idx_q       <= idx_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_bn_q    <= out_bn_d;
         err_q       <= err_d;
      end
   end

   // Block storage needs no reset; its contents are only read after a full block is written.
   always_ff @(posedge clk) begin
      blk_q <= blk_d;
   end

   assign in_ready     = (state_q == ACCEPT);
   assign out          = out_q;
   assign out_valid    = out_valid_q;
   assign out_last     = out_last_q;
   assign out_byte_num = out_bn_q;
   assign err          = err_q;

endmodule
